// File: rtl/pixel_scanner.sv
// Framebuffer read-out: walks the pixel byte address over an H x V frame and
// streams one byte per RAM word lane as a valid/ready pixel stream with markers.
module pixel_scanner #(
  parameter int         H_PIXELS  = 32,
  parameter int         V_LINES   = 32,
  parameter logic [9:0] BASE_ADDR = 10'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        continuous,
  output logic [9:0]  pixel_address,
  input  logic [31:0] pixel_word,
  output logic [7:0]  pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_eof,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [9:0] X_LAST = 10'(H_PIXELS - 1);
  localparam logic [9:0] Y_LAST = 10'(V_LINES - 1);

  state_t     state, state_next;
  logic [9:0] x, y;
  logic       load, accept, eof_accept;
  logic       last_x, last_pixel;
  logic [7:0] byte_sel;

  // A new pixel is fetched whenever the output register is empty or being drained.
  assign load       = (state == RUN) && (!pix_valid || pix_ready);
  assign accept     = pix_valid && pix_ready;
  assign eof_accept = accept && pix_eof;
  assign last_x     = (x == X_LAST);
  assign last_pixel = last_x && (y == Y_LAST);
  assign busy       = (state != IDLE);

  always_comb begin
    byte_sel = pixel_word[7:0];
    unique case (pixel_address[1:0])
      2'd0:    byte_sel = pixel_word[7:0];
      2'd1:    byte_sel = pixel_word[15:8];
      2'd2:    byte_sel = pixel_word[23:16];
      default: byte_sel = pixel_word[31:24];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (load && last_pixel && !continuous) state_next = DRAIN;
      DRAIN:   if (eof_accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Continuous mode reloads the scan position on the eof load so the next
  // frame follows without a bubble; single-shot rewinds only on entry to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      x             <= '0;
      y             <= '0;
      pixel_address <= BASE_ADDR;
      pix_data      <= '0;
      pix_valid     <= 1'b0;
      pix_sof       <= 1'b0;
      pix_eol       <= 1'b0;
      pix_eof       <= 1'b0;
      frame_done    <= 1'b0;
      frame_count   <= '0;
    end else begin
      if (load) begin
        pix_data  <= byte_sel;
        pix_valid <= 1'b1;
        pix_sof   <= (x == '0) && (y == '0);
        pix_eol   <= last_x;
        pix_eof   <= last_pixel;
        if (last_pixel) begin
          x             <= '0;
          y             <= '0;
          pixel_address <= continuous ? BASE_ADDR : pixel_address + 10'd1;
        end else if (last_x) begin
          x             <= '0;
          y             <= y + 10'd1;
          pixel_address <= pixel_address + 10'd1;
        end else begin
          x             <= x + 10'd1;
          pixel_address <= pixel_address + 10'd1;
        end
      end else begin
        if (accept) pix_valid <= 1'b0;
        if (state_next == IDLE) begin
          x             <= '0;
          y             <= '0;
          pixel_address <= BASE_ADDR;
        end
      end
      frame_done <= eof_accept;
      if (eof_accept) frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pixel_scanner.sv
// Directed bench for pixel_scanner: 4x2 frames from a small RAM model, plus a
// second instance based at byte 1020 to exercise address wrap-around.
module tb_pixel_scanner;

  logic        clk = 1'b0;
  logic        reset, start, continuous, pix_ready;
  logic [9:0]  pixel_address;
  logic [31:0] pixel_word;
  logic [7:0]  pix_data;
  logic        pix_valid, pix_sof, pix_eol, pix_eof, busy, frame_done;
  logic [15:0] frame_count;

  logic        start_w;
  logic [9:0]  addr_w;
  logic [31:0] word_w;
  logic [7:0]  data_w;
  logic        valid_w, sof_w, eol_w, eof_w, busy_w, done_w;
  logic [15:0] fc_w;

  logic [31:0] ram [256];
  logic [7:0]  exp_data [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  logic [7:0]  exp_wrap [8] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};
  logic [3:0]  ready_pat = 4'b1001;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign pixel_word = ram[pixel_address[9:2]];
  assign word_w     = ram[addr_w[9:2]];

  pixel_scanner #(.H_PIXELS(4), .V_LINES(2), .BASE_ADDR(10'd0)) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .pixel_address(pixel_address), .pixel_word(pixel_word),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
  );

  pixel_scanner #(.H_PIXELS(4), .V_LINES(2), .BASE_ADDR(10'd1020)) dut_w (
    .clk(clk), .reset(reset), .start(start_w), .continuous(1'b0),
    .pixel_address(addr_w), .pixel_word(word_w),
    .pix_data(data_w), .pix_valid(valid_w), .pix_ready(1'b1),
    .pix_sof(sof_w), .pix_eol(eol_w), .pix_eof(eof_w),
    .busy(busy_w), .frame_done(done_w), .frame_count(fc_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_pixel(input string tag, input int idx);
    check($sformatf("%s_px%0d_valid", tag, idx), 32'(pix_valid), 32'd1);
    check($sformatf("%s_px%0d_data", tag, idx), 32'(pix_data), 32'(exp_data[idx]));
    check($sformatf("%s_px%0d_sof", tag, idx), 32'(pix_sof), 32'(idx == 0));
    check($sformatf("%s_px%0d_eol", tag, idx), 32'(pix_eol), 32'(idx == 3 || idx == 7));
    check($sformatf("%s_px%0d_eof", tag, idx), 32'(pix_eof), 32'(idx == 7));
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_T1"}, 32'(busy), 32'd1);
    check({tag, "_novalid_T1"}, 32'(pix_valid), 32'd0);
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"}, 32'(pixel_address), 32'd0);
    check({tag, "_data"}, 32'(pix_data), 32'd0);
    check({tag, "_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_markers"}, 32'({pix_sof, pix_eol, pix_eof}), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(frame_done), 32'd0);
    check({tag, "_fc"}, 32'(frame_count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int idx;
    int cyc;
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[0]   = 32'h44332211;
    ram[1]   = 32'h88776655;
    ram[255] = 32'hDDCCBBAA;
    reset = 1'b1; start = 1'b0; continuous = 1'b0; pix_ready = 1'b1; start_w = 1'b0;
    repeat (2) @(negedge clk);

    check_reset_values("rst");
    check("rst_addr_w", 32'(addr_w), 32'd1020);
    reset = 1'b0;
    tick();

    // Single-shot frame, ready held high.
    do_start("single");
    for (int k = 0; k < 8; k++) begin
      expect_pixel("single", k);
      check($sformatf("single_addr%0d", k), 32'(pixel_address), k + 1);
      tick();
    end
    check("single_done", 32'(frame_done), 32'd1);
    check("single_fc", 32'(frame_count), 32'd1);
    check("single_busy", 32'(busy), 32'd0);
    check("single_valid_off", 32'(pix_valid), 32'd0);
    check("single_addr_rewind", 32'(pixel_address), 32'd0);
    tick();
    check("single_done_pulse", 32'(frame_done), 32'd0);

    // Back-pressure with ready pattern 1,0,0,1.
    do_start("stall");
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 64) begin
      expect_pixel("stall", idx);
      check($sformatf("stall_addr_c%0d", cyc), 32'(pixel_address), idx + 1);
      pix_ready = ready_pat[cyc % 4];
      tick();
      if (pix_ready) idx++;
      cyc++;
    end
    check("stall_pixel_count", idx, 8);
    check("stall_cycles", cyc, 16);
    pix_ready = 1'b1;
    check("stall_done", 32'(frame_done), 32'd1);
    check("stall_fc", 32'(frame_count), 32'd2);
    check("stall_busy", 32'(busy), 32'd0);

    // Continuous: three back-to-back frames, continuous dropped during the third.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("cont_fc_cleared", 32'(frame_count), 32'd0);
    continuous = 1'b1;
    do_start("cont");
    for (int k = 0; k < 24; k++) begin
      expect_pixel($sformatf("cont%0d", k / 8), k % 8);
      check($sformatf("cont_done_k%0d", k), 32'(frame_done), 32'(k == 8 || k == 16));
      check($sformatf("cont_fc_k%0d", k), 32'(frame_count), k / 8);
      if (k == 18) continuous = 1'b0;
      tick();
    end
    check("cont_done_last", 32'(frame_done), 32'd1);
    check("cont_fc_last", 32'(frame_count), 32'd3);
    check("cont_busy", 32'(busy), 32'd0);
    tick();
    check("cont_stopped", 32'(pix_valid), 32'd0);
    check("cont_idle", 32'(busy), 32'd0);

    // Address wrap from byte 1023 to byte 0.
    check("wrap_idle_addr", 32'(addr_w), 32'd1020);
    start_w = 1'b1;
    tick();
    start_w = 1'b0;
    check("wrap_busy", 32'(busy_w), 32'd1);
    tick();
    for (int k = 0; k < 8; k++) begin
      check($sformatf("wrap_px%0d_valid", k), 32'(valid_w), 32'd1);
      check($sformatf("wrap_px%0d_data", k), 32'(data_w), 32'(exp_wrap[k]));
      check($sformatf("wrap_px%0d_addr", k), 32'(addr_w), (1021 + k) % 1024);
      check($sformatf("wrap_px%0d_marks", k), 32'({sof_w, eol_w, eof_w}),
            32'({k == 0, k == 3 || k == 7, k == 7}));
      tick();
    end
    check("wrap_done", 32'(done_w), 32'd1);
    check("wrap_fc", 32'(fc_w), 32'd1);
    check("wrap_addr_rewind", 32'(addr_w), 32'd1020);

    // Reset after the third pixel of a frame.
    do_start("rmid");
    for (int k = 0; k < 3; k++) begin
      expect_pixel("rmid", k);
      if (k < 2) tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_values("rmid");
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("rmid_nodone%0d", k), 32'(frame_done), 32'd0);
    end
    do_start("rclean");
    for (int k = 0; k < 8; k++) begin
      expect_pixel("rclean", k);
      tick();
    end
    check("rclean_done", 32'(frame_done), 32'd1);
    check("rclean_fc", 32'(frame_count), 32'd1);

    // start pulses while busy are ignored.
    do_start("sbusy");
    for (int k = 0; k < 8; k++) begin
      expect_pixel("sbusy", k);
      start = (k == 2 || k == 5);
      tick();
    end
    start = 1'b0;
    check("sbusy_done", 32'(frame_done), 32'd1);
    check("sbusy_fc", 32'(frame_count), 32'd2);
    check("sbusy_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("sbusy_quiet_valid%0d", k), 32'(pix_valid), 32'd0);
      check($sformatf("sbusy_quiet_done%0d", k), 32'(frame_done), 32'd0);
      check($sformatf("sbusy_quiet_busy%0d", k), 32'(busy), 32'd0);
    end

    // start coincident with reset: reset wins.
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("rs_busy", 32'(busy), 32'd0);
    check("rs_fc", 32'(frame_count), 32'd0);
    tick();
    check("rs_busy_later", 32'(busy), 32'd0);
    check("rs_valid_later", 32'(pix_valid), 32'd0);
    tick();
    check("rs_valid_later2", 32'(pix_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_scanner.md
# pixel_scanner

Framebuffer read-out stage that sits directly downstream of the program/data block RAM's pixel read port. It walks the pixel byte address over a configurable H×V frame, selects one 8-bit pixel from each 32-bit word returned by the RAM, and presents the pixels as a valid/ready stream with frame and line markers to the display driver. It supports single-shot and continuous (free-running refresh) frames and keeps a frame counter for software and debug.

## Interface

One clock; reset is synchronous and active-high.

Parameters:
- H_PIXELS, 32, pixels per line (1..1024)
- V_LINES, 32, lines per frame (1..1024); H_PIXELS*V_LINES ≤ 1024
- BASE_ADDR, 0, 10-bit byte address of pixel (0,0)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a frame; ignored unless IDLE
- continuous  in  1  1 = restart automatically after the last pixel
- pixel_address  out  10  byte address driven to the RAM pixel port; word index = [9:2]
- pixel_word  in  32  RAM pixel read data, combinational from pixel_address
- pix_data  out  8  pixel byte
- pix_valid  out  1  pix_data and markers valid
- pix_ready  in  1  downstream accepts when pix_valid & pix_ready
- pix_sof  out  1  first pixel of frame
- pix_eol  out  1  last pixel of a line
- pix_eof  out  1  last pixel of frame
- busy  out  1  state ≠ IDLE
- frame_done  out  1  one-cycle pulse after the eof pixel is accepted
- frame_count  out  16  completed frames, wraps 0xFFFF→0

## Operation

- States: IDLE, RUN, DRAIN.
- IDLE: pixel_address = BASE_ADDR; x = y = 0. start → RUN.
- load = RUN & (!pix_valid | pix_ready). On load:
  - pix_data = pixel_word[8*a+7:8*a], where a = pixel_address[1:0] (little-endian).
  - pix_sof = (x==0 & y==0); pix_eol = (x==H_PIXELS-1); pix_eof = pix_eol & (y==V_LINES-1).
  - Advance: x++ and pixel_address++; at end of line x→0, y++.
- The address increments modulo 1024, so frames wrap from byte 1023 to byte 0.
- On the load of the eof pixel:
  - continuous = 1: x, y and pixel_address reload to 0, 0, BASE_ADDR, and the state stays RUN. The next frame streams with no bubble.
  - continuous = 0: go to DRAIN.
  - continuous is sampled only at this point.
- DRAIN: no loads. When the eof pixel is accepted → IDLE.
- When pix_valid & pix_ready and no load occurs in the same cycle, pix_valid → 0.
- frame_done is asserted for the cycle after the eof pixel handshake, and frame_count increments on the same edge. This applies in both continuous and single-shot modes.
- Reset mid-frame: state → IDLE. No frame_done pulse; frame_count is cleared.
- start while busy is ignored. start and reset in the same cycle: reset wins.

## Timing

- Reset values:
  - state = IDLE
  - pixel_address = BASE_ADDR
  - pix_data = 0
  - pix_valid = 0
  - pix_sof = pix_eol = pix_eof = 0
  - busy = 0
  - frame_done = 0
  - frame_count = 0
- start sampled high at edge T:
  - busy = 1 from cycle T+1.
  - The first load happens at edge T+1, so pix_valid = 1 with pixel (0,0) in cycle T+2.
- Throughput is 1 pixel/clk while pix_ready = 1. Frame latency = H*V + 1 cycles from start to eof valid.
- Back-pressure: while pix_valid & !pix_ready, pix_data and all markers hold stable, and pixel_address does not change.
- pixel_address changes only on load edges. RAM data must settle within the same cycle, because the RAM read is combinational.
- Eof accepted at edge E:
  - frame_done = 1 during cycle E+1.
  - frame_count is updated in cycle E+1.
  - Single-shot: busy = 0 in cycle E+1, and the block can accept a new start in cycle E+1.

## Test plan

- Single frame, H=4, V=2, BASE=0, RAM words 0x44332211 and 0x88776655, pix_ready=1:
  - Stream is 11,22,33,44,55,66,77,88 on consecutive cycles starting T+2.
  - sof on 11; eol on 44 and 88; eof on 88.
  - frame_done 1 cycle after 88 is accepted; frame_count=1; busy=0.
- Same frame with pix_ready toggling 1,0,0,1,…:
  - Each pixel is held stable while ready=0.
  - No pixels are duplicated or dropped.
  - pixel_address is frozen while stalled.
- continuous=1 for two frames:
  - 11…88 is followed immediately by 11 (with sof) with no gap cycle.
  - frame_done pulses twice; frame_count=2.
  - Drop continuous during frame 3: the block stops after that frame's 88 and returns to IDLE.
- Wrap: BASE=1020, H=4, V=2:
  - pixel_address sequence is 1020..1023, 0..3.
  - pix_data comes from word 255, then word 0.
- Reset asserted in the middle of frame (after the 3rd pixel):
  - All outputs return to reset values in the next cycle.
  - No frame_done pulse; frame_count=0.
  - A following start produces a clean frame from 11.
- start pulsed while busy (twice mid-frame):
  - Ignored; exactly one frame of 8 pixels and one frame_done.
  - start in the same cycle as reset: remains IDLE.
